// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: character animation FSM plus sprite-sheet address
// generation and ROM read-data realignment for the VGA color mapper.
// Optional feature macro: SPRITE_MIRROR_EN (horizontal mirror on facing_left).
`timescale 1ns/1ps

module sprite_pixel_fetch #(
    parameter int          SHEET_W        = 360,
    parameter int          FRAME_W        = 60,
    parameter int          FRAME_H        = 105,
    parameter int          FRAMES_PER_ROW = 6,
    parameter int          ANIM_DIV       = 4,
    parameter logic [23:0] KEY_RGB        = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  PosX,
    input  logic [9:0]  PosY,
    input  logic        walk,
    input  logic        attack,
    input  logic        facing_left,
    input  logic [23:0] rom_data,
    output logic [18:0] read_address,
    output logic        sprite_on,
    output logic [23:0] sprite_rgb,
    output logic [3:0]  anim_frame,
    output logic        busy
);

    // state     | meaning
    // ST_IDLE   | standing still, frame 0
    // ST_WALK   | walk cycle, frames 1..5
    // ST_ATTACK | attack animation, frames 6..11, ignores new requests
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_ATTACK = 2'd2
    } state_t;

    localparam logic [3:0] WALK_FIRST = 4'd1;
    localparam logic [3:0] WALK_LAST  = 4'd5;
    localparam logic [3:0] ATK_FIRST  = 4'd6;
    localparam logic [3:0] ATK_LAST   = 4'd11;
    localparam logic [7:0] DIV_LAST   = 8'(ANIM_DIV - 1);

    state_t      state, state_n;
    logic [3:0]  frame_n;
    logic [7:0]  div_cnt, div_n;
    logic        pending, pending_n;
    logic [2:0]  sync_q;
    logic        tick;
    logic        in_box, in_box_d;

    // Two-flop synchroniser for frame_clk plus one flop for rising-edge detect.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) sync_q <= 3'b000;
        else       sync_q <= {sync_q[1:0], frame_clk};
    end

    assign tick = sync_q[1] & ~sync_q[2];

    // Animation state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            anim_frame <= 4'd0;
            div_cnt    <= 8'd0;
            pending    <= 1'b0;
        end else begin
            state      <= state_n;
            anim_frame <= frame_n;
            div_cnt    <= div_n;
            pending    <= pending_n;
        end
    end

    // Next-state logic: requests latch any cycle, the FSM only moves on tick.
    always_comb begin
        state_n   = state;
        frame_n   = anim_frame;
        div_n     = div_cnt;
        pending_n = pending;
        if (attack && (state != ST_ATTACK))
            pending_n = 1'b1;
        if (tick) begin
            case (state)
                ST_IDLE, ST_WALK: begin
                    if (pending) begin
                        state_n   = ST_ATTACK;
                        frame_n   = ATK_FIRST;
                        div_n     = 8'd0;
                        pending_n = 1'b0;
                    end else if (!walk) begin
                        state_n = ST_IDLE;
                        frame_n = 4'd0;
                        div_n   = 8'd0;
                    end else if (state == ST_IDLE) begin
                        state_n = ST_WALK;
                        frame_n = WALK_FIRST;
                        div_n   = 8'd0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_n   = 8'd0;
                        frame_n = (anim_frame == WALK_LAST) ? WALK_FIRST : anim_frame + 4'd1;
                    end else begin
                        div_n = div_cnt + 8'd1;
                    end
                end
                ST_ATTACK: begin
                    if (div_cnt == DIV_LAST) begin
                        div_n = 8'd0;
                        if (anim_frame == ATK_LAST) begin
                            state_n = walk ? ST_WALK : ST_IDLE;
                            frame_n = walk ? WALK_FIRST : 4'd0;
                        end else begin
                            frame_n = anim_frame + 4'd1;
                        end
                    end else begin
                        div_n = div_cnt + 8'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    frame_n = 4'd0;
                    div_n   = 8'd0;
                end
            endcase
        end
    end

    assign busy = (state == ST_ATTACK);

    // Bounding box: ends are formed in 11 bits so a sprite near x/y=1023 does not wrap.
    logic [10:0] x_end, y_end;
    logic [9:0]  dx, dy;

    assign x_end  = {1'b0, PosX} + 11'(FRAME_W);
    assign y_end  = {1'b0, PosY} + 11'(FRAME_H);
    assign in_box = (DrawX >= PosX) && ({1'b0, DrawX} < x_end) &&
                    (DrawY >= PosY) && ({1'b0, DrawY} < y_end);
    assign dx     = DrawX - PosX;
    assign dy     = DrawY - PosY;

`ifndef SPRITE_MIRROR_EN
    logic unused_facing;
    assign unused_facing = facing_left;
`endif

    // Sheet address: frame tile origin plus row stride plus column.
    always_comb begin
        logic [18:0] col, row, tile_row, tile_col, base;
        col      = {9'd0, dx};
`ifdef SPRITE_MIRROR_EN
        if (facing_left)
            col = 19'(FRAME_W - 1) - {9'd0, dx};
`endif
        row      = {9'd0, dy};
        tile_row = {15'd0, anim_frame} / 19'(FRAMES_PER_ROW);
        tile_col = {15'd0, anim_frame} - tile_row * 19'(FRAMES_PER_ROW);
        base     = tile_row * 19'(FRAME_H * SHEET_W) + tile_col * 19'(FRAME_W);
        read_address = in_box ? (base + row * 19'(SHEET_W) + col) : 19'd0;
    end

    // Delay in_box alongside the ROM's address register so it lines up with rom_data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) in_box_d <= 1'b0;
        else       in_box_d <= in_box;
    end

    assign sprite_on  = in_box_d && (rom_data != KEY_RGB);
    assign sprite_rgb = sprite_on ? rom_data : 24'h0;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a behavioural animation/address model.
`timescale 1ns/1ps

module tb_sprite_pixel_fetch;

    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX, DrawY, PosX, PosY;
    logic        walk, attack, facing_left;
    logic [23:0] rom_data;
    logic [18:0] read_address;
    logic        sprite_on;
    logic [23:0] sprite_rgb;
    logic [3:0]  anim_frame;
    logic        busy;

    sprite_pixel_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .PosX         (PosX),
        .PosY         (PosY),
        .walk         (walk),
        .attack       (attack),
        .facing_left  (facing_left),
        .rom_data     (rom_data),
        .read_address (read_address),
        .sprite_on    (sprite_on),
        .sprite_rgb   (sprite_rgb),
        .anim_frame   (anim_frame),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Model: m_state 0 idle, 1 walk, 2 attack; m_ticks counts ticks since entering the state.
    int m_state = 0, m_ticks = 0, m_frame = 0;
    bit m_pending = 0;
    bit in_tick = 0;
    bit inbox_prev = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_inbox(int x, int y, int px, int py);
        return (x >= px) && (x < px + 60) && (y >= py) && (y < py + 105);
    endfunction

    function automatic int model_addr(int x, int y, int px, int py, int fr, bit fl);
        int col, row, base;
        if (!model_inbox(x, y, px, py)) return 0;
        col = x - px;
`ifdef SPRITE_MIRROR_EN
        if (fl) col = 59 - col;
`endif
        row  = y - py;
        base = (fr / 6) * 105 * 360 + (fr % 6) * 60;
        return base + row * 360 + col;
    endfunction

    function automatic void model_tick();
        if (m_state == 2) begin
            m_ticks++;
            if (m_ticks == 24) begin
                m_state = walk ? 1 : 0;
                m_frame = walk ? 1 : 0;
                m_ticks = 0;
            end else begin
                m_frame = 6 + m_ticks / 4;
            end
        end else if (m_pending) begin
            m_state = 2; m_frame = 6; m_ticks = 0; m_pending = 0;
        end else if (walk) begin
            if (m_state == 0) begin
                m_state = 1; m_frame = 1; m_ticks = 0;
            end else begin
                m_ticks++;
                m_frame = 1 + (m_ticks / 4) % 5;
            end
        end else begin
            m_state = 0; m_frame = 0; m_ticks = 0;
        end
    endfunction

    // Compare process: every cycle, outputs against the model.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (!in_tick) begin
                check("read_address", read_address,
                      model_addr(DrawX, DrawY, PosX, PosY, m_frame, facing_left));
                check("anim_frame", anim_frame, m_frame);
                check("busy", busy, (m_state == 2) ? 1 : 0);
            end
            check("sprite_on", sprite_on, (inbox_prev && rom_data != KEY) ? 1 : 0);
            check("sprite_rgb", sprite_rgb,
                  (inbox_prev && rom_data != KEY) ? int'(rom_data) : 0);
        end
        inbox_prev = Reset ? 1'b0 : model_inbox(DrawX, DrawY, PosX, PosY);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_tick();
        in_tick = 1;
        model_tick();
        frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        in_tick = 0;
    endtask

    task automatic attack_pulse();
        attack = 1'b1;
        if (m_state != 2) m_pending = 1;
        step();
        attack = 1'b0;
        step();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; walk = 1'b0; attack = 1'b0; facing_left = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd500; PosY = 10'd500; rom_data = 24'h0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_anim_frame", anim_frame, 0);
        check("rst_busy", busy, 0);
        check("rst_sprite_on", sprite_on, 0);
        check("rst_sprite_rgb", sprite_rgb, 0);
        Reset = 1'b0;
        step();

        // Addressing, frame 0
        PosX = 10'd100; PosY = 10'd50; DrawX = 10'd100; DrawY = 10'd50;
        #1 check("addr_top_left", read_address, 0);
        step();
        DrawX = 10'd159; DrawY = 10'd154; rom_data = 24'h123456;
        #1 check("addr_bottom_right", read_address, 37499);
        step();
        check("opaque_on", sprite_on, 1);
        check("opaque_rgb", sprite_rgb, 24'h123456);
        rom_data = KEY;
        #1 check("key_on", sprite_on, 0);
        check("key_rgb", sprite_rgb, 0);
        step();
        rom_data = 24'h123456; DrawX = 10'd160;
        #1 check("addr_right_edge", read_address, 0);
        step();
        check("right_edge_on", sprite_on, 0);
        // near the 1023 edge: no wrap of PosX+FRAME_W
        PosX = 10'd1000; DrawX = 10'd5; DrawY = 10'd60;
        #1 check("addr_no_wrap", read_address, 0);
        step();

        // Walk cycle
        walk = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            do_tick();
            if (i == 4)  check("walk_t4", anim_frame, 1);
            if (i == 5)  check("walk_t5", anim_frame, 2);
            if (i == 20) check("walk_t20", anim_frame, 5);
            if (i == 21) check("walk_t21", anim_frame, 1);
        end
        walk = 1'b0;
        do_tick();
        check("walk_drop", anim_frame, 0);

        // Attack from walk
        walk = 1'b1;
        do_tick();
        attack_pulse();
        do_tick();
        check("atk_frame6", anim_frame, 6);
        check("atk_busy", busy, 1);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) attack_pulse();
            do_tick();
        end
        PosX = 10'd0; PosY = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
        #1 check("addr_frame7", read_address, 37860);
        step();
        for (int i = 5; i <= 20; i++) do_tick();
        check("atk_frame11", anim_frame, 11);
        for (int i = 1; i <= 4; i++) do_tick();
        check("atk_exit_frame", anim_frame, 1);
        check("atk_exit_busy", busy, 0);
        do_tick();

        // Reset mid-attack at frame 8
        walk = 1'b0;
        do_tick();
        attack_pulse();
        do_tick();
        for (int i = 1; i <= 8; i++) do_tick();
        check("atk_frame8", anim_frame, 8);
        PosX = 10'd100; PosY = 10'd50; DrawX = 10'd120; DrawY = 10'd60; rom_data = 24'hABCDEF;
        step();
        check("pre_reset_on", sprite_on, 1);
        #2 Reset = 1'b1;
        #1;
        check("midrst_frame", anim_frame, 0);
        check("midrst_busy", busy, 0);
        check("midrst_on", sprite_on, 0);
        m_state = 0; m_frame = 0; m_ticks = 0; m_pending = 0;
        step();
        Reset = 1'b0;
        step();
        step();

        // Mirror request
        facing_left = 1'b1; DrawX = 10'd100; DrawY = 10'd50;
`ifdef SPRITE_MIRROR_EN
        #1 check("mirror_col", read_address, 59);
`else
        #1 check("mirror_ignored", read_address, 0);
`endif
        step();
        DrawX = 10'd130; DrawY = 10'd51;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
